// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared size codes, FSM states and default depth for the memory access unit
package mem_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_RSVD = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_MEM_RD = 2'b01,
    ST_MEM_WR = 2'b10,
    ST_RSP    = 2'b11
  } state_e;

  localparam int MEM_DEPTH = 128;

endpackage

// File: rtl/mem_lane_align.sv
// rtl/mem_lane_align.sv - little-endian lane merge for stores and lane extract/extend for loads
module mem_lane_align
  import mem_pkg::*;
(
  input  logic [31:0] old_word,
  input  logic [31:0] new_data,
  input  size_e       size,
  input  logic [1:0]  lane,
  input  logic        is_unsigned,
  output logic [31:0] merged,
  output logic [31:0] load_data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel  = old_word[{lane, 3'b000} +: 8];
    half_sel  = old_word[{lane[1], 4'b0000} +: 16];
    merged    = new_data;
    load_data = old_word;
    case (size)
      SZ_BYTE: begin
        merged                       = old_word;
        merged[{lane, 3'b000} +: 8]  = new_data[7:0];
        load_data = is_unsigned ? {24'd0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
      end
      SZ_HALF: begin
        merged                          = old_word;
        merged[{lane[1], 4'b0000} +: 16] = new_data[15:0];
        load_data = is_unsigned ? {16'd0, half_sel} : {{16{half_sel[15]}}, half_sel};
      end
      default: begin
        merged    = new_data;
        load_data = old_word;
      end
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - load/store sequencer with read-modify-write for sub-word stores
// Optional fault detection (misalignment, reserved size, out-of-range index) under MEM_ALIGN_CHECK_EN.
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int DEPTH  = MEM_DEPTH,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ReqValid,
  output logic              ReqReady,
  input  logic              ReqWrite,
  input  logic [1:0]        ReqSize,
  input  logic              ReqUnsigned,
  input  logic [ADDR_W-1:0] ReqAddr,
  input  logic [31:0]       ReqWData,
  output logic              RspValid,
  output logic [31:0]       RspData,
  output logic              RspErr,
  output logic              MemRead,
  output logic              MemWrite,
  output logic [31:0]       Address,
  output logic [31:0]       WriteData,
  input  logic [31:0]       ReadData
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int LA_W  = IDX_W + 2;

  state_e          state_q, state_d;
  logic            write_q, write_d;
  size_e           size_q, size_d;
  logic            uns_q, uns_d;
  logic [LA_W-1:0] addr_q, addr_d;
  logic [31:0]     wdata_q, wdata_d;
  logic [31:0]     rdata_q, rdata_d;
  logic            err_q, err_d;

  size_e           req_size;
  logic            fault;
  logic [31:0]     merged;
  logic [31:0]     load_data;
  logic [ADDR_W-1:0] unused_addr;

  assign unused_addr = ReqAddr;

  always_comb begin
    req_size = size_e'(ReqSize);
`ifdef MEM_ALIGN_CHECK_EN
    fault = (req_size == SZ_RSVD)
         || (req_size == SZ_HALF && ReqAddr[0])
         || (req_size == SZ_WORD && ReqAddr[1:0] != 2'b00)
         || ((ReqAddr >> 2) >= ADDR_W'(DEPTH));
`else
    fault = 1'b0;
    if (req_size == SZ_RSVD) req_size = SZ_WORD;
`endif
  end

  mem_lane_align u_lane_align (
    .old_word    (rdata_q),
    .new_data    (wdata_q),
    .size        (size_q),
    .lane        (addr_q[1:0]),
    .is_unsigned (uns_q),
    .merged      (merged),
    .load_data   (load_data)
  );

  // Memory-side outputs decode only registered state so the combinational write port never sees glitches.
  always_comb begin
    state_d   = state_q;
    write_d   = write_q;
    size_d    = size_q;
    uns_d     = uns_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    err_d     = err_q;
    ReqReady  = 1'b0;
    RspValid  = 1'b0;
    RspData   = 32'd0;
    RspErr    = 1'b0;
    MemRead   = 1'b0;
    MemWrite  = 1'b0;
    Address   = 32'd0;
    WriteData = 32'd0;
    case (state_q)
      ST_IDLE: begin
        ReqReady = 1'b1;
        if (ReqValid) begin
          write_d = ReqWrite;
          size_d  = req_size;
          uns_d   = ReqUnsigned;
          addr_d  = ReqAddr[LA_W-1:0];
          wdata_d = ReqWData;
          err_d   = fault;
          if (fault)                               state_d = ST_RSP;
          else if (ReqWrite && req_size == SZ_WORD) state_d = ST_MEM_WR;
          else                                     state_d = ST_MEM_RD;
        end
      end
      ST_MEM_RD: begin
        MemRead = 1'b1;
        Address = 32'(addr_q[LA_W-1:2]);
        rdata_d = ReadData;
        state_d = write_q ? ST_MEM_WR : ST_RSP;
      end
      ST_MEM_WR: begin
        MemWrite  = 1'b1;
        Address   = 32'(addr_q[LA_W-1:2]);
        WriteData = merged;
        state_d   = ST_RSP;
      end
      ST_RSP: begin
        RspValid = 1'b1;
        RspErr   = err_q;
        RspData  = (write_q || err_q) ? 32'd0 : load_data;
        state_d  = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      write_q <= 1'b0;
      size_q  <= SZ_BYTE;
      uns_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= 32'd0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      write_q <= write_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - directed self-checking bench for mem_access_unit with a 128-word memory model
module tb_mem_access_unit;

  logic        clk;
  logic        rst_n;
  logic        ReqValid;
  logic        ReqReady;
  logic        ReqWrite;
  logic [1:0]  ReqSize;
  logic        ReqUnsigned;
  logic [31:0] ReqAddr;
  logic [31:0] ReqWData;
  logic        RspValid;
  logic [31:0] RspData;
  logic        RspErr;
  logic        MemRead;
  logic        MemWrite;
  logic [31:0] Address;
  logic [31:0] WriteData;
  logic [31:0] ReadData;

  int pass_cnt;
  int total_cnt;

  logic [31:0] mem [0:127];
  logic        preload_en;
  logic [6:0]  preload_idx;
  logic [31:0] preload_val;

  mem_access_unit #(.DEPTH(128), .ADDR_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .ReqValid(ReqValid), .ReqReady(ReqReady), .ReqWrite(ReqWrite), .ReqSize(ReqSize),
    .ReqUnsigned(ReqUnsigned), .ReqAddr(ReqAddr), .ReqWData(ReqWData),
    .RspValid(RspValid), .RspData(RspData), .RspErr(RspErr),
    .MemRead(MemRead), .MemWrite(MemWrite), .Address(Address), .WriteData(WriteData),
    .ReadData(ReadData)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign ReadData = mem[Address[6:0]];

  always @(posedge clk) begin
    if (MemWrite) mem[Address[6:0]] <= WriteData;
    else if (preload_en) mem[preload_idx] <= preload_val;
  end

  initial begin
    #200000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [6:0] idx, input logic [31:0] val);
    preload_en  = 1'b1;
    preload_idx = idx;
    preload_val = val;
    tick();
    preload_en  = 1'b0;
  endtask

  // Presents one request, returns 1 time unit into T1.
  task automatic do_req(input logic wr, input logic [1:0] sz, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wd);
    int waited;
    waited = 0;
    while (ReqReady !== 1'b1 && waited < 20) begin
      tick();
      waited++;
    end
    total_cnt++;
    if (waited >= 20) $display("FAIL req_ready_wait act=%0b exp=1", ReqReady); else pass_cnt++;
    ReqValid = 1'b1; ReqWrite = wr; ReqSize = sz; ReqUnsigned = uns; ReqAddr = addr; ReqWData = wd;
    tick();
    ReqValid = 1'b0; ReqWrite = 1'b0; ReqSize = 2'b00; ReqAddr = 32'd0; ReqWData = 32'd0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    #1;
    total_cnt++; if (ReqReady !== 1'b1) $display("FAIL rst_ready act=%0b exp=1", ReqReady); else pass_cnt++;
    total_cnt++;
    if ({RspValid, RspErr, MemRead, MemWrite} !== 4'b0 || RspData !== 32'd0 || Address !== 32'd0 || WriteData !== 32'd0)
      $display("FAIL rst_outputs act=%0b%0b%0b%0b %h %h %h exp=0000 0 0 0", RspValid, RspErr, MemRead, MemWrite, RspData, Address, WriteData);
    else pass_cnt++;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_word_store;
    preload(7'd4, 32'h0);
    do_req(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF);
    total_cnt++; if (MemWrite !== 1'b1 || MemRead !== 1'b0) $display("FAIL ws_memwrite act=%0b%0b exp=10", MemWrite, MemRead); else pass_cnt++;
    total_cnt++; if (Address !== 32'd4) $display("FAIL ws_address act=%h exp=00000004", Address); else pass_cnt++;
    total_cnt++; if (WriteData !== 32'hDEADBEEF) $display("FAIL ws_wdata act=%h exp=deadbeef", WriteData); else pass_cnt++;
    total_cnt++; if (ReqReady !== 1'b0) $display("FAIL ws_busy act=%0b exp=0", ReqReady); else pass_cnt++;
    tick();
    total_cnt++; if (RspValid !== 1'b1 || RspErr !== 1'b0 || RspData !== 32'd0) $display("FAIL ws_rsp act=%0b%0b %h exp=10 00000000", RspValid, RspErr, RspData); else pass_cnt++;
    total_cnt++; if (mem[4] !== 32'hDEADBEEF) $display("FAIL ws_mem act=%h exp=deadbeef", mem[4]); else pass_cnt++;
    tick();
    do_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
    total_cnt++; if (MemRead !== 1'b1 || Address !== 32'd4) $display("FAIL wl_read act=%0b %h exp=1 00000004", MemRead, Address); else pass_cnt++;
    tick();
    total_cnt++; if (RspValid !== 1'b1 || RspData !== 32'hDEADBEEF) $display("FAIL wl_rsp act=%0b %h exp=1 deadbeef", RspValid, RspData); else pass_cnt++;
    tick();
  endtask

  task automatic test_byte_store;
    preload(7'd4, 32'h11223344);
    do_req(1'b1, 2'b00, 1'b0, 32'h13, 32'hFFFFFFA5);
    total_cnt++; if (MemRead !== 1'b1 || MemWrite !== 1'b0 || Address !== 32'd4) $display("FAIL bs_t1 act=%0b%0b %h exp=10 00000004", MemRead, MemWrite, Address); else pass_cnt++;
    tick();
    total_cnt++; if (MemWrite !== 1'b1 || WriteData !== 32'hA5223344) $display("FAIL bs_t2 act=%0b %h exp=1 a5223344", MemWrite, WriteData); else pass_cnt++;
    tick();
    total_cnt++; if (RspValid !== 1'b1 || RspData !== 32'd0) $display("FAIL bs_t3 act=%0b %h exp=1 00000000", RspValid, RspData); else pass_cnt++;
    total_cnt++; if (mem[4] !== 32'hA5223344) $display("FAIL bs_mem act=%h exp=a5223344", mem[4]); else pass_cnt++;
    tick();
  endtask

  task automatic test_loads;
    logic [31:0] addrs [5];
    logic [1:0]  sizes [5];
    logic        unss  [5];
    logic [31:0] exps  [5];
    addrs = '{32'h13, 32'h13, 32'h12, 32'h10, 32'h11};
    sizes = '{2'b00, 2'b00, 2'b01, 2'b01, 2'b00};
    unss  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    exps  = '{32'hFFFFFFA5, 32'h000000A5, 32'hFFFFA522, 32'h00003344, 32'h00000033};
    for (int i = 0; i < 5; i++) begin
      do_req(1'b0, sizes[i], unss[i], addrs[i], 32'h0);
      tick();
      total_cnt++;
      if (RspValid !== 1'b1 || RspData !== exps[i]) $display("FAIL load_%0d act=%0b %h exp=1 %h", i, RspValid, RspData, exps[i]);
      else pass_cnt++;
      tick();
    end
  endtask

  task automatic test_half_store;
    do_req(1'b1, 2'b01, 1'b0, 32'h12, 32'h1234BEEF);
    tick();
    total_cnt++; if (MemWrite !== 1'b1 || WriteData !== 32'hBEEF3344) $display("FAIL hs_t2 act=%0b %h exp=1 beef3344", MemWrite, WriteData); else pass_cnt++;
    tick();
    total_cnt++; if (RspValid !== 1'b1) $display("FAIL hs_t3 act=%0b exp=1", RspValid); else pass_cnt++;
    tick();
  endtask

  task automatic test_misaligned;
    preload(7'd1, 32'hCAFEF00D);
    preload(7'd0, 32'h0BADC0DE);
    do_req(1'b0, 2'b10, 1'b0, 32'h06, 32'h0);
`ifdef MEM_ALIGN_CHECK_EN
    total_cnt++; if (MemRead !== 1'b0 || RspValid !== 1'b1 || RspErr !== 1'b1 || RspData !== 32'd0) $display("FAIL mis_fault act=%0b%0b%0b %h exp=011 00000000", MemRead, RspValid, RspErr, RspData); else pass_cnt++;
    tick();
    do_req(1'b0, 2'b10, 1'b0, 32'h200, 32'h0);
    total_cnt++; if (MemRead !== 1'b0 || RspValid !== 1'b1 || RspErr !== 1'b1) $display("FAIL range_fault act=%0b%0b%0b exp=011", MemRead, RspValid, RspErr); else pass_cnt++;
    tick();
`else
    total_cnt++; if (MemRead !== 1'b1 || Address !== 32'd1) $display("FAIL mis_read act=%0b %h exp=1 00000001", MemRead, Address); else pass_cnt++;
    tick();
    total_cnt++; if (RspValid !== 1'b1 || RspErr !== 1'b0 || RspData !== 32'hCAFEF00D) $display("FAIL mis_rsp act=%0b%0b %h exp=10 cafef00d", RspValid, RspErr, RspData); else pass_cnt++;
    tick();
    do_req(1'b0, 2'b11, 1'b0, 32'h04, 32'h0);
    tick();
    total_cnt++; if (RspData !== 32'hCAFEF00D) $display("FAIL rsvd_as_word act=%h exp=cafef00d", RspData); else pass_cnt++;
    tick();
    do_req(1'b0, 2'b10, 1'b0, 32'h200, 32'h0);
    total_cnt++; if (Address !== 32'd0 || MemRead !== 1'b1) $display("FAIL idx_trunc act=%h %0b exp=00000000 1", Address, MemRead); else pass_cnt++;
    tick();
    total_cnt++; if (RspData !== 32'h0BADC0DE) $display("FAIL idx_trunc_data act=%h exp=0badc0de", RspData); else pass_cnt++;
    tick();
`endif
  endtask

  task automatic test_reset_mid;
    logic bad;
    preload(7'd4, 32'h11223344);
    do_req(1'b1, 2'b00, 1'b0, 32'h13, 32'h000000A5);
    rst_n = 1'b0;
    #1;
    total_cnt++; if (MemRead !== 1'b0 || Address !== 32'd0 || ReqReady !== 1'b1) $display("FAIL mid_rst_now act=%0b %h %0b exp=0 00000000 1", MemRead, Address, ReqReady); else pass_cnt++;
    bad = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (MemWrite !== 1'b0 || RspValid !== 1'b0) bad = 1'b1;
    end
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (MemWrite !== 1'b0 || RspValid !== 1'b0) bad = 1'b1;
    end
    total_cnt++; if (bad !== 1'b0) $display("FAIL mid_rst_quiet act=%0b exp=0", bad); else pass_cnt++;
    total_cnt++; if (mem[4] !== 32'h11223344) $display("FAIL mid_rst_mem act=%h exp=11223344", mem[4]); else pass_cnt++;
    do_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
    tick();
    total_cnt++; if (RspValid !== 1'b1 || RspData !== 32'h11223344) $display("FAIL mid_rst_after act=%0b %h exp=1 11223344", RspValid, RspData); else pass_cnt++;
    tick();
  endtask

  task automatic test_back_to_back;
    ReqValid = 1'b1; ReqWrite = 1'b0; ReqSize = 2'b10; ReqUnsigned = 1'b0; ReqAddr = 32'h10; ReqWData = 32'h0;
    tick();
    total_cnt++; if (ReqReady !== 1'b0) $display("FAIL b2b_t1_ready act=%0b exp=0", ReqReady); else pass_cnt++;
    ReqWrite = 1'b1; ReqSize = 2'b00; ReqAddr = 32'h04; ReqWData = 32'h55555555;
    tick();
    total_cnt++; if (ReqReady !== 1'b0 || RspValid !== 1'b1 || RspData !== 32'h11223344) $display("FAIL b2b_t2 act=%0b%0b %h exp=01 11223344", ReqReady, RspValid, RspData); else pass_cnt++;
    ReqWrite = 1'b0; ReqSize = 2'b10; ReqAddr = 32'h04; ReqWData = 32'h0;
    tick();
    total_cnt++; if (ReqReady !== 1'b1 || RspValid !== 1'b0) $display("FAIL b2b_t3 act=%0b%0b exp=10", ReqReady, RspValid); else pass_cnt++;
    tick();
    ReqValid = 1'b0;
    total_cnt++; if (ReqReady !== 1'b0 || MemRead !== 1'b1 || Address !== 32'd1) $display("FAIL b2b_t4 act=%0b%0b %h exp=01 00000001", ReqReady, MemRead, Address); else pass_cnt++;
    tick();
    total_cnt++; if (RspValid !== 1'b1 || RspData !== 32'hCAFEF00D) $display("FAIL b2b_t5 act=%0b %h exp=1 cafef00d", RspValid, RspData); else pass_cnt++;
    total_cnt++; if (mem[1] !== 32'hCAFEF00D) $display("FAIL b2b_mem act=%h exp=cafef00d", mem[1]); else pass_cnt++;
    tick();
  endtask

  initial begin
    pass_cnt = 0; total_cnt = 0;
    rst_n = 1'b0; ReqValid = 1'b0; ReqWrite = 1'b0; ReqSize = 2'b00; ReqUnsigned = 1'b0;
    ReqAddr = 32'd0; ReqWData = 32'd0;
    preload_en = 1'b0; preload_idx = 7'd0; preload_val = 32'd0;
    tick();
    test_reset();
    test_word_store();
    test_byte_store();
    test_loads();
    test_half_store();
    test_misaligned();
    test_reset_mid();
    test_back_to_back();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
